// File: rtl/loader_pkg.sv
// Shared types and defaults for the switch-driven memory loader.
package loader_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_ADDR_W          = 8;
    localparam int unsigned DEF_DATA_W          = 16;
    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned STATE_W             = 2;
    localparam int unsigned COUNT_W             = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_LO = 2'd0,
        ST_HI = 2'd1,
        ST_WR = 2'd2
    } loader_state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low pushbutton; emits a one-cycle pulse per press.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press_evt
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             key_sync;
    logic             key_stable;
    logic [CNT_W-1:0] cnt;

    // A level change is accepted only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a     <= 1'b1;
            key_sync   <= 1'b1;
            key_stable <= 1'b1;
            cnt        <= '0;
            press_evt  <= 1'b0;
        end else begin
            sync_a    <= key_raw;
            key_sync  <= sync_a;
            press_evt <= 1'b0;
            if (key_sync == key_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_stable <= key_sync;
                cnt        <= '0;
                press_evt  <= key_stable & ~key_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_mem_loader.sv
// Byte-wise entry of memory words from SW[7:0] and one KEY, with auto-incrementing address.
module sw_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned DATA_W          = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_raw,
    input  logic [BYTE_W-1:0]   sw,
    input  logic                set_addr,
    input  logic                load_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    output logic                mem_we,
    output logic [STATE_W-1:0]  state_out,
    output logic [COUNT_W-1:0]  word_count
);

    loader_state_e       state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   shadow_q;
    logic [COUNT_W-1:0]  count_q;
    logic                we_q;
    logic                press_evt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .press_evt(press_evt)
    );

    // we_q is raised on the edge entering WR so it mirrors state_q == ST_WR exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_LO;
            addr_q   <= '0;
            shadow_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_LO: begin
                    if (press_evt && load_en) begin
                        if (set_addr) begin
                            addr_q <= ADDR_W'(sw);
                        end else begin
                            shadow_q[BYTE_W-1:0] <= sw;
                            state_q              <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (!load_en) begin
                        state_q <= ST_LO;
                    end else if (press_evt) begin
                        shadow_q[2*BYTE_W-1:BYTE_W] <= sw;
                        state_q                     <= ST_WR;
                        we_q                        <= 1'b1;
                    end
                end
                ST_WR: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q + COUNT_W'(1);
                    state_q <= ST_LO;
                end
                default: begin
                    state_q <= ST_LO;
                end
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_din    = shadow_q;
    assign mem_we     = we_q;
    assign state_out  = state_q;
    assign word_count = count_q;

endmodule
